// File: rtl/fifo_rx_checker.sv
`default_nettype none
// ============================================================================
// fifo_rx_checker : read-side FIFO consumer; pops via rd_en and checks each
// word against the (n*STEP) mod 2^W pattern. Optional macro: RX_CAPTURE_EN.
// Revision 1.0
// ============================================================================
module fifo_rx_checker #(
  parameter int W           = 8,
  parameter int NUM_WORDS   = 64,
  parameter int STEP        = 2,
  parameter int STOP_ON_ERR = 0
`ifdef RX_CAPTURE_EN
  , parameter int CAP_DEPTH = 16
`endif
) (
  input  logic                         read_clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         hold,
  input  logic                         r_empty,
  input  logic [W-1:0]                 data_in,
  output logic                         rd_en,
  output logic                         word_valid,
  output logic [W-1:0]                 word_data,
  output logic [15:0]                  word_count,
  output logic [15:0]                  err_count,
  output logic                         err_seen,
  output logic [15:0]                  first_err_idx,
`ifdef RX_CAPTURE_EN
  input  logic [$clog2(CAP_DEPTH)-1:0] cap_addr,
  output logic [W-1:0]                 cap_data,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [15:0]  LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [W-1:0] STEP_W   = W'(STEP);

  state_t       state_q, state_d;
  logic [W-1:0] expected_q, expected_d;
  logic [W-1:0] word_data_q, word_data_d;
  logic         word_valid_q, word_valid_d;
  logic [15:0]  word_count_q, word_count_d;
  logic [15:0]  err_count_q, err_count_d;
  logic         err_seen_q, err_seen_d;
  logic [15:0]  first_err_idx_q, first_err_idx_d;
  logic         mismatch;

  assign rd_en    = (state_q == S_RUN) & ~r_empty & ~hold;
  assign mismatch = rd_en & (data_in != expected_q);

  always_comb begin
    state_d         = state_q;
    expected_d      = expected_q;
    word_data_d     = word_data_q;
    word_valid_d    = 1'b0;
    word_count_d    = word_count_q;
    err_count_d     = err_count_q;
    err_seen_d      = err_seen_q;
    first_err_idx_d = first_err_idx_q;

    if (state_q != S_RUN) begin
      if (start) begin
        state_d         = S_RUN;
        expected_d      = '0;
        word_count_d    = '0;
        err_count_d     = '0;
        err_seen_d      = 1'b0;
        first_err_idx_d = '0;
      end
    end else if (rd_en) begin
      word_data_d  = data_in;
      word_valid_d = 1'b1;
      word_count_d = word_count_q + 16'd1;
      expected_d   = expected_q + STEP_W;
      if (mismatch) begin
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        if (!err_seen_q) begin
          first_err_idx_d = word_count_q;
          err_seen_d      = 1'b1;
        end
      end
      // An abort on the last word wins over normal completion.
      if ((STOP_ON_ERR != 0) && mismatch) state_d = S_ABORT;
      else if (word_count_q == LAST_IDX)  state_d = S_DONE;
    end
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      expected_q      <= '0;
      word_data_q     <= '0;
      word_valid_q    <= 1'b0;
      word_count_q    <= '0;
      err_count_q     <= '0;
      err_seen_q      <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      expected_q      <= expected_d;
      word_data_q     <= word_data_d;
      word_valid_q    <= word_valid_d;
      word_count_q    <= word_count_d;
      err_count_q     <= err_count_d;
      err_seen_q      <= err_seen_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign word_data     = word_data_q;
  assign word_valid    = word_valid_q;
  assign word_count    = word_count_q;
  assign err_count     = err_count_q;
  assign err_seen      = err_seen_q;
  assign first_err_idx = first_err_idx_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign aborted       = (state_q == S_ABORT);

`ifdef RX_CAPTURE_EN
  localparam int AW = $clog2(CAP_DEPTH);

  logic [W-1:0] cap_mem [CAP_DEPTH];
  logic [W-1:0] cap_data_q;

  // The pre-increment word count doubles as the write index, so it restarts
  // with every run while the stored contents survive start and reset.
  always_ff @(posedge read_clk) begin
    if (rd_en && (word_count_q < 16'(CAP_DEPTH)))
      cap_mem[word_count_q[AW-1:0]] <= data_in;
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) cap_data_q <= '0;
    else          cap_data_q <= cap_mem[cap_addr];
  end

  assign cap_data = cap_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rx_checker.sv
`default_nettype none
// ============================================================================
// tb_fifo_rx_checker : scoreboard bench; three checker instances (default,
// STOP_ON_ERR=1, NUM_WORDS=200) fed by per-instance FIFO source models.
// Revision 1.0
// ============================================================================
module tb_fifo_rx_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start, hold, r_empty;
  logic corrupt;

  logic [7:0]  din [3];
  logic [7:0]  wd  [3];
  logic [15:0] wc  [3];
  logic [15:0] ec  [3];
  logic [15:0] fei [3];
  logic        rd  [3];
  logic        wv  [3];
  logic        es  [3];
  logic        bz  [3];
  logic        dn  [3];
  logic        ab  [3];
  int          idx [3];

`ifdef RX_CAPTURE_EN
  logic [3:0] cap_addr [3];
  logic [7:0] cap_data [3];
`endif

  int n_checks = 0;
  int n_err    = 0;
  int pops     = 0;
  logic [7:0] sb_q [$];

  logic hold_en, gap_en;
  logic [15:0] wc_hold;
  logic prev_hold;

  always #5 clk = ~clk;

  fifo_rx_checker #(.W(8), .NUM_WORDS(64), .STEP(2), .STOP_ON_ERR(0)) u_dut (
    .read_clk(clk), .reset_n(rst_n), .start(start), .hold(hold), .r_empty(r_empty),
    .data_in(din[0]), .rd_en(rd[0]), .word_valid(wv[0]), .word_data(wd[0]),
    .word_count(wc[0]), .err_count(ec[0]), .err_seen(es[0]), .first_err_idx(fei[0]),
`ifdef RX_CAPTURE_EN
    .cap_addr(cap_addr[0]), .cap_data(cap_data[0]),
`endif
    .busy(bz[0]), .done(dn[0]), .aborted(ab[0]));

  fifo_rx_checker #(.W(8), .NUM_WORDS(64), .STEP(2), .STOP_ON_ERR(1)) u_dut_abort (
    .read_clk(clk), .reset_n(rst_n), .start(start), .hold(hold), .r_empty(r_empty),
    .data_in(din[1]), .rd_en(rd[1]), .word_valid(wv[1]), .word_data(wd[1]),
    .word_count(wc[1]), .err_count(ec[1]), .err_seen(es[1]), .first_err_idx(fei[1]),
`ifdef RX_CAPTURE_EN
    .cap_addr(cap_addr[1]), .cap_data(cap_data[1]),
`endif
    .busy(bz[1]), .done(dn[1]), .aborted(ab[1]));

  fifo_rx_checker #(.W(8), .NUM_WORDS(200), .STEP(2), .STOP_ON_ERR(0)) u_dut_wrap (
    .read_clk(clk), .reset_n(rst_n), .start(start), .hold(hold), .r_empty(r_empty),
    .data_in(din[2]), .rd_en(rd[2]), .word_valid(wv[2]), .word_data(wd[2]),
    .word_count(wc[2]), .err_count(ec[2]), .err_seen(es[2]), .first_err_idx(fei[2]),
`ifdef RX_CAPTURE_EN
    .cap_addr(cap_addr[2]), .cap_data(cap_data[2]),
`endif
    .busy(bz[2]), .done(dn[2]), .aborted(ab[2]));

  // FIFO source model: head word is the ROM pattern at the pop index,
  // optionally with words 10 and 20 corrupted.
  function automatic logic [7:0] src_word(input int i, input logic corr);
    if (corr && i == 10) return 8'hFF;
    if (corr && i == 20) return 8'h00;
    return 8'((2 * i) % 256);
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) din[k] = src_word(idx[k], corrupt);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) idx[k] <= 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (start)      idx[k] <= 0;
        else if (rd[k]) idx[k] <= idx[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: the popped head word is pushed at the pop, and popped when
  // word_valid presents it one cycle later.
  always @(negedge clk) begin
    if (wv[0]) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                  check("sb_word", {24'd0, wd[0]}, {24'd0, sb_q.pop_front()});
    end
    if (rd[0]) begin
      sb_q.push_back(din[0]);
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_drive(input int cyc);
    tick();
    start   = (cyc == 0);
    hold    = hold_en && (cyc >= 5) && (cyc <= 14);
    r_empty = gap_en && (((cyc / 3) % 2) == 1);
    #1;
    if (r_empty) check("rd_while_empty", {31'd0, rd[0]}, 32'd0);
    if (hold) begin
      check("rd_while_hold", {31'd0, rd[0]}, 32'd0);
      if (prev_hold) check("wc_frozen", {16'd0, wc[0]}, {16'd0, wc_hold});
      wc_hold = wc[0];
    end
    prev_hold = hold;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wc"},  {16'd0, wc[0]},  32'd0);
    check({tag, "_ec"},  {16'd0, ec[0]},  32'd0);
    check({tag, "_fei"}, {16'd0, fei[0]}, 32'd0);
    check({tag, "_wd"},  {24'd0, wd[0]},  32'd0);
    check({tag, "_flags"},
          {25'd0, es[0], wv[0], rd[0], bz[0], dn[0], ab[0], 1'b0}, 32'd0);
  endtask

  // Starts a run and clocks until every instance leaves RUN; when rst_at is
  // non-negative, asserts reset mid-cycle once word_count reaches it.
  task automatic run(input int bound, input int rst_at);
    int cyc;
    prev_hold = 1'b0;
    for (cyc = 0; cyc < bound; cyc++) begin
      cycle_drive(cyc);
      if (rst_at >= 0 && wc[0] == 16'(rst_at)) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        break;
      end
      if (cyc > 1 && !bz[0] && !bz[1] && !bz[2]) break;
    end
    if (cyc >= bound) check("run_timeout", 32'd1, 32'd0);
    start   = 1'b0;
    hold    = 1'b0;
    r_empty = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    r_empty = 1'b0;
    corrupt = 1'b0;
    hold_en = 1'b0;
    gap_en  = 1'b0;
    wc_hold = '0;
    prev_hold = 1'b0;
`ifdef RX_CAPTURE_EN
    for (int k = 0; k < 3; k++) cap_addr[k] = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");

    // Clean run on all instances; the 200-word instance crosses the wrap.
    pops = 0;
    run(1000, -1);
    check("clean_pops",  pops, 64);
    check("clean_wc",    {16'd0, wc[0]}, 64);
    check("clean_ec",    {16'd0, ec[0]}, 0);
    check("clean_es",    {31'd0, es[0]}, 0);
    check("clean_done",  {31'd0, dn[0]}, 1);
    check("clean_rd",    {31'd0, rd[0]}, 0);
    check("wrap_wc",     {16'd0, wc[2]}, 200);
    check("wrap_ec",     {16'd0, ec[2]}, 0);
    check("wrap_done",   {31'd0, dn[2]}, 1);

`ifdef RX_CAPTURE_EN
    for (int a = 0; a < 16; a++) begin
      cap_addr[0] = 4'(a);
      tick();
      check("cap_data", {24'd0, cap_data[0]}, 32'((2 * a) % 256));
    end
`endif

    // Back-pressure window; outputs must also have held in DONE meanwhile.
    check("done_hold_wc", {16'd0, wc[0]}, 64);
    hold_en = 1'b1;
    run(1000, -1);
    hold_en = 1'b0;
    check("bp_wc",   {16'd0, wc[0]}, 64);
    check("bp_ec",   {16'd0, ec[0]}, 0);
    check("bp_done", {31'd0, dn[0]}, 1);

    // Error injection on words 10 and 20.
    corrupt = 1'b1;
    run(1000, -1);
    corrupt = 1'b0;
    check("err_ec",      {16'd0, ec[0]},  2);
    check("err_fei",     {16'd0, fei[0]}, 10);
    check("err_es",      {31'd0, es[0]},  1);
    check("err_done",    {31'd0, dn[0]},  1);
    check("abort_flag",  {31'd0, ab[1]},  1);
    check("abort_done",  {31'd0, dn[1]},  0);
    check("abort_wc",    {16'd0, wc[1]},  11);
    check("abort_ec",    {16'd0, ec[1]},  1);
    check("abort_fei",   {16'd0, fei[1]}, 10);
    check("abort_rd",    {31'd0, rd[1]},  0);
    check("wrap_err_ec", {16'd0, ec[2]},  2);

    // Empty gaps with a mid-run reset, then a fresh gapped run.
    gap_en = 1'b1;
    run(2000, 30);
    tick();
    check_reset_outputs("post_rst");
    run(2000, -1);
    gap_en = 1'b0;
    check("gap_wc",   {16'd0, wc[0]}, 64);
    check("gap_ec",   {16'd0, ec[0]}, 0);
    check("gap_es",   {31'd0, es[0]}, 0);
    check("gap_done", {31'd0, dn[0]}, 1);

    tick();
    tick();
    check("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
